phase_delay_ctrl: RTL and testbench
===================================

Name: phase_delay_ctrl

Overview:
- Configures the downstream programmable delay line, replacing a fixed wait count with one derived from a commanded phase.
- Measures the period of the reference input in clk cycles and computes wait_cnt = period * phase / 2^PHASE_BITS.
- Applies each new value only on a reference rising edge, so the delay line never sees a mid-cycle change.
- Sits between the host phase register and the delay line's wait-count input.

Parameters:
- WAIT_CNT_SIZE, 11: width of the period counter, period and wait_cnt.
- PHASE_BITS, 8: phase command width; the LSB is 1/2^PHASE_BITS of a period.
- LOCK_CNT, 4: number of consecutive in-tolerance periods required for lock.
- TOL, 1: maximum allowed |period - previous period| in cycles.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sig_in  in  1  reference signal, asynchronous to clk
- phase_cmd  in  PHASE_BITS  commanded phase fraction
- phase_load  in  1  one-cycle strobe; samples phase_cmd
- wait_cnt  out  WAIT_CNT_SIZE  delay-line wait count
- period  out  WAIT_CNT_SIZE  last measured period in cycles
- period_valid  out  1  period holds a valid measurement
- lock  out  1  LOCK_CNT consecutive periods within TOL
- too_fast  out  1  measured period < PHASE_BITS+3; no update performed

Behaviour:
- Reset (async assert, sync deassert):
  - wait_cnt=0, period=0, period_valid=0, lock=0, too_fast=0.
  - phase_reg=0, cnt=0, lock counter=0, state=IDLE.
- sig_in passes through a 2-flop synchronizer, then a rising-edge detector; edge pulse "e" is high one cycle, 3 cycles after the sig_in rise.
- cnt clears on e, otherwise increments and saturates at 2^WAIT_CNT_SIZE-1.
- On e (states other than IDLE): measured period = cnt+1.
- phase_load: phase_reg <= phase_cmd on the same edge.
- States:
  - IDLE: wait for first e, then go to MEASURE; no period yet.
  - MEASURE: on e, latch period and set period_valid=1.
    - If period < PHASE_BITS+3: set too_fast=1, stay in MEASURE.
    - Else: clear too_fast and go to CALC.
  - CALC: sequential shift-add multiply of period * phase_reg, one phase bit per cycle, PHASE_BITS cycles.
    - The result is truncated: bits [PHASE_BITS+WAIT_CNT_SIZE-1:PHASE_BITS] of the product.
    - It is stored in "pending" and the FSM goes to ARMED.
  - ARMED: on e, wait_cnt <= pending (same cycle), the new period is latched and checked, then back to CALC (or to MEASURE if too fast).
- Update latency: the first valid wait_cnt appears on the 3rd detected edge after reset. Steady state applies the value computed from the previous period.
- phase_load during CALC: CALC restarts from bit 0 with the new phase_reg on the next cycle.
- phase_load in ARMED: re-enter CALC; the stale pending value is discarded.
- Lock:
  - On each e with period_valid, a period within TOL of the previous one increments the lock counter (saturating at LOCK_CNT); otherwise the counter is cleared.
  - lock = (counter == LOCK_CNT).
- Timeout: cnt reaching saturation (no edge) clears period_valid, lock, the lock counter and too_fast, and sends the FSM to IDLE. wait_cnt holds its last value.
- e arriving while in CALC (period shorter than CALC duration, only possible on a jump):
  - period is latched and the lock check runs.
  - too_fast is set if the period is below threshold.
  - CALC restarts with the new period; wait_cnt is not updated.
- phase_cmd=0 gives wait_cnt=0. The maximum phase gives period*(2^PHASE_BITS-1)>>PHASE_BITS and never overflows.
- Reset asserted mid-CALC or mid-ARMED: all state returns to reset values immediately; pending is discarded.

Test Plan:
- sig_in period 64 clk cycles, phase_load with phase_cmd=0x40 -> period=64, period_valid=1, wait_cnt=16 from the 3rd edge on, lock=1 after 4 further edges.
- Period 32, phase_cmd=0x80, then phase_load 0xC0 mid-stream -> wait_cnt 16, then 24 applied exactly on an e cycle. wait_cnt never changes off an e cycle.
- sig_in held low after lock -> 2047 cycles after the last e: period_valid=0, lock=0, FSM=IDLE, wait_cnt unchanged. Edges resuming give a fresh 3-edge acquisition.
- Period 8 (< 11) -> too_fast=1, wait_cnt unchanged. Switching to period 64 clears too_fast and updates wait_cnt.
- Period alternating 64/66 with TOL=1 -> lock stays 0. Alternating 64/65 -> lock=1 after 4 edges.
- rst_n pulsed low mid-CALC (async, between clk edges) -> all outputs 0 immediately. After release, the first e enters MEASURE.

Source files
------------

// File: rtl/phase_delay_ctrl.sv
// Purpose : derives the delay-line wait count as period * phase / 2^PHASE_BITS from a measured reference period.
// Latency : first wait_cnt on the 3rd detected reference edge; steady state applies the value computed from the previous period.
// Backpres: none; wait_cnt changes only on a detected reference rising edge, never mid-cycle of the reference.
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   sig_in          reference signal, asynchronous to clk
//   phase_cmd       commanded phase fraction (LSB = 1/2^PHASE_BITS of a period)
//   phase_load      one-cycle strobe sampling phase_cmd
//   wait_cnt        delay-line wait count
//   period          last measured reference period in clk cycles
//   period_valid    period holds a valid measurement
//   lock            LOCK_CNT consecutive periods within TOL of their predecessor
//   too_fast        last period below PHASE_BITS+3; no wait_cnt update computed
module phase_delay_ctrl #(
    parameter int WAIT_CNT_SIZE = 11,
    parameter int PHASE_BITS    = 8,
    parameter int LOCK_CNT      = 4,
    parameter int TOL           = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sig_in,
    input  logic [PHASE_BITS-1:0]    phase_cmd,
    input  logic                     phase_load,
    output logic [WAIT_CNT_SIZE-1:0] wait_cnt,
    output logic [WAIT_CNT_SIZE-1:0] period,
    output logic                     period_valid,
    output logic                     lock,
    output logic                     too_fast
);

    localparam int PROD_W = WAIT_CNT_SIZE + PHASE_BITS;
    localparam int LCW    = $clog2(LOCK_CNT + 1);
    localparam int BCW    = $clog2(PHASE_BITS + 1);

    localparam logic [WAIT_CNT_SIZE-1:0] CNT_MAX    = '1;
    localparam logic [WAIT_CNT_SIZE-1:0] MIN_PERIOD = WAIT_CNT_SIZE'(PHASE_BITS + 3);
    localparam logic [WAIT_CNT_SIZE-1:0] TOL_W      = WAIT_CNT_SIZE'(TOL);
    localparam logic [LCW-1:0]           LOCK_MAX   = LCW'(LOCK_CNT);
    localparam logic [BCW-1:0]           LAST_BIT   = BCW'(PHASE_BITS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        CALC    = 2'd2,
        ARMED   = 2'd3
    } state_t;

    state_t                   state;
    logic [PHASE_BITS-1:0]    phase_reg;
    logic [WAIT_CNT_SIZE-1:0] cnt;
    logic [LCW-1:0]           lock_cnt;
    logic [WAIT_CNT_SIZE-1:0] pending;

    // Shift-add multiplier state: multiplicand shifts left, multiplier
    // shifts right, one phase bit consumed per cycle starting at the LSB.
    logic [PROD_W-1:0]        acc;
    logic [PROD_W-1:0]        mcand;
    logic [PHASE_BITS-1:0]    mplier;
    logic [BCW-1:0]           bit_cnt;

    logic                     sync_meta;
    logic                     sync_stable;
    logic                     sync_prev;
    logic                     edge_pulse;

    logic                     timeout;
    logic [WAIT_CNT_SIZE-1:0] meas;
    logic [WAIT_CNT_SIZE-1:0] period_diff;
    logic                     in_tol;
    logic                     fast;
    logic [LCW-1:0]           lock_cnt_nxt;
    logic [PROD_W-1:0]        acc_nxt;

    // Two-flop synchronizer plus a delayed copy for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta   <= 1'b0;
            sync_stable <= 1'b0;
            sync_prev   <= 1'b0;
        end else begin
            sync_meta   <= sig_in;
            sync_stable <= sync_meta;
            sync_prev   <= sync_stable;
        end
    end

    assign edge_pulse = sync_stable & ~sync_prev;

    // Period counter: cleared on every edge, saturates when the reference stops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (edge_pulse) begin
            cnt <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + WAIT_CNT_SIZE'(1);
        end
    end

    // Timeout fires on the clock edge where the counter reaches saturation
    // (and keeps firing while it stays there, which is harmless).
    assign timeout = !edge_pulse && (cnt >= (CNT_MAX - WAIT_CNT_SIZE'(1)));

    // The edge clears cnt on the same clock that ends the interval, so the
    // interval length is one more than the count accumulated so far.
    assign meas        = cnt + WAIT_CNT_SIZE'(1);
    assign period_diff = (meas >= period) ? (meas - period) : (period - meas);
    assign in_tol      = period_valid && (period_diff <= TOL_W);
    assign fast        = (meas < MIN_PERIOD);

    always_comb begin
        lock_cnt_nxt = '0;
        if (in_tol) begin
            lock_cnt_nxt = (lock_cnt == LOCK_MAX) ? lock_cnt : lock_cnt + LCW'(1);
        end
    end

    assign acc_nxt = acc + (mplier[0] ? mcand : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            phase_reg    <= '0;
            wait_cnt     <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            lock         <= 1'b0;
            too_fast     <= 1'b0;
            lock_cnt     <= '0;
            pending      <= '0;
            acc          <= '0;
            mcand        <= '0;
            mplier       <= '0;
            bit_cnt      <= '0;
        end else begin
            if (phase_load) begin
                phase_reg <= phase_cmd;
            end

            if (timeout) begin
                // Reference lost: drop the measurement but keep driving the
                // last wait count so the delay line stays where it was.
                period_valid <= 1'b0;
                lock         <= 1'b0;
                lock_cnt     <= '0;
                too_fast     <= 1'b0;
                state        <= IDLE;
            end else if (edge_pulse) begin
                if (state == IDLE) begin
                    // First edge only starts the interval; nothing to measure yet.
                    state <= MEASURE;
                end else begin
                    // Only a finished product may reach the delay line; an
                    // edge landing in CALC just restarts the computation.
                    if (state == ARMED) begin
                        wait_cnt <= pending;
                    end
                    period       <= meas;
                    period_valid <= 1'b1;
                    lock_cnt     <= lock_cnt_nxt;
                    lock         <= (lock_cnt_nxt == LOCK_MAX);
                    if (fast) begin
                        too_fast <= 1'b1;
                        state    <= MEASURE;
                    end else begin
                        too_fast <= 1'b0;
                        state    <= CALC;
                        acc      <= '0;
                        mcand    <= PROD_W'(meas);
                        // A phase strobe on the edge cycle is honoured directly.
                        mplier   <= phase_load ? phase_cmd : phase_reg;
                        bit_cnt  <= '0;
                    end
                end
            end else if (phase_load && (state == CALC || state == ARMED)) begin
                // New phase invalidates any partial or pending product.
                state   <= CALC;
                acc     <= '0;
                mcand   <= PROD_W'(period);
                mplier  <= phase_cmd;
                bit_cnt <= '0;
            end else if (state == CALC) begin
                acc     <= acc_nxt;
                mcand   <= mcand << 1;
                mplier  <= mplier >> 1;
                bit_cnt <= bit_cnt + BCW'(1);
                if (bit_cnt == LAST_BIT) begin
                    // Dividing by 2^PHASE_BITS is a truncating bit select;
                    // period*(2^PHASE_BITS-1) always fits the upper field.
                    pending <= acc_nxt[PROD_W-1:PHASE_BITS];
                    state   <= ARMED;
                end
            end
        end
    end

endmodule

// File: tb/tb_phase_delay_ctrl.sv
module tb_phase_delay_ctrl;

    localparam int W     = 11;
    localparam int PB    = 8;
    localparam int LOCKN = 4;
    localparam int TOLV  = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sig_in = 1'b0;
    logic [PB-1:0] phase_cmd = '0;
    logic          phase_load = 1'b0;
    logic [W-1:0]  wait_cnt;
    logic [W-1:0]  period;
    logic          period_valid;
    logic          lock;
    logic          too_fast;

    phase_delay_ctrl #(
        .WAIT_CNT_SIZE(W),
        .PHASE_BITS   (PB),
        .LOCK_CNT     (LOCKN),
        .TOL          (TOLV)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sig_in       (sig_in),
        .phase_cmd    (phase_cmd),
        .phase_load   (phase_load),
        .wait_cnt     (wait_cnt),
        .period       (period),
        .period_valid (period_valid),
        .lock         (lock),
        .too_fast     (too_fast)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected output snapshot, taking effect from cycle 'due' onward.
    typedef struct {
        int due;
        int w;
        int p;
        bit pv;
        bit lk;
        bit tf;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   fails = 0;
    bit   done = 1'b0;
    bit   final_done = 1'b0;

    // Reference model: acquisition state, last period, lock run length.
    typedef enum { M_IDLE, M_ACQ, M_RUN } mstate_t;
    mstate_t mst = M_IDLE;
    int m_wait = 0, m_period = 0, m_lockc = 0, m_phase = 0;
    bit m_pv = 1'b0, m_tf = 1'b0;
    int last_rise = 0, last_due = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_snap(input int due);
        exp_t x;
        x.due = due;
        x.w   = m_wait;
        x.p   = m_period;
        x.pv  = m_pv;
        x.lk  = (m_lockc == LOCKN);
        x.tf  = m_tf;
        q.push_back(x);
    endtask

    // A rise driven just after clock c is acted on at clock c+3.
    task automatic model_edge(input int c);
        int p;
        int due;
        p   = c - last_rise;
        due = c + 3;
        if (mst == M_IDLE) begin
            mst = M_ACQ;
        end else begin
            if (mst == M_RUN)
                m_wait = (m_period * m_phase) / (1 << PB);
            if (m_pv && (p - m_period <= TOLV) && (m_period - p <= TOLV))
                m_lockc = (m_lockc < LOCKN) ? m_lockc + 1 : LOCKN;
            else
                m_lockc = 0;
            m_period = p;
            m_pv     = 1'b1;
            if (p < PB + 3) begin
                m_tf = 1'b1;
                mst  = M_ACQ;
            end else begin
                m_tf = 1'b0;
                mst  = M_RUN;
            end
            push_snap(due);
        end
        last_rise = c;
        last_due  = due;
    endtask

    // Rising edge p cycles after the previous one, high for 4 cycles;
    // an optional phase load lands one clock after the edge is acted on.
    task automatic do_edge(input int p, input bit ld, input int ph);
        while (cyc < last_rise + p) step();
        sig_in = 1'b1;
        model_edge(cyc);
        repeat (3) step();
        if (ld) begin
            phase_cmd  = ph[PB-1:0];
            phase_load = 1'b1;
            m_phase    = ph & ((1 << PB) - 1);
        end
        step();
        phase_load = 1'b0;
        sig_in     = 1'b0;
    endtask

    task automatic load_now(input int ph);
        phase_cmd  = ph[PB-1:0];
        phase_load = 1'b1;
        m_phase    = ph & ((1 << PB) - 1);
        step();
        phase_load = 1'b0;
    endtask

    // Reference held low; the counter saturates 2047 clocks after the last edge.
    task automatic idle(input int n);
        int tdue;
        tdue = last_due + ((1 << W) - 1);
        if (mst != M_IDLE && tdue < cyc + n + 3) begin
            m_pv    = 1'b0;
            m_lockc = 0;
            m_tf    = 1'b0;
            mst     = M_IDLE;
            push_snap(tdue);
        end
        repeat (n) step();
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #3;
        rst_n    = 1'b0;
        mst      = M_IDLE;
        m_wait   = 0;
        m_period = 0;
        m_pv     = 1'b0;
        m_lockc  = 0;
        m_tf     = 1'b0;
        m_phase  = 0;
        repeat (3) step();
        rst_n = 1'b1;
        last_rise = cyc;
        repeat (2) step();
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, req);
        end
    endtask

    // Monitor: applies due snapshots and compares every output every cycle.
    int e_w = 0, e_p = 0;
    bit e_pv = 1'b0, e_lk = 1'b0, e_tf = 1'b0;

    initial begin
        exp_t x;
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                #1;
                q.delete();
                e_w  = 0;
                e_p  = 0;
                e_pv = 1'b0;
                e_lk = 1'b0;
                e_tf = 1'b0;
            end else begin
                while (q.size() > 0 && q[0].due <= cyc) begin
                    x    = q.pop_front();
                    e_w  = x.w;
                    e_p  = x.p;
                    e_pv = x.pv;
                    e_lk = x.lk;
                    e_tf = x.tf;
                end
            end
            check("wait_cnt", int'(wait_cnt), e_w);
            check("period", int'(period), e_p);
            check("period_valid", int'(period_valid), int'(e_pv));
            check("lock", int'(lock), int'(e_lk));
            check("too_fast", int'(too_fast), int'(e_tf));
            if (done && !final_done) begin
                check("queue_drained", q.size(), 0);
                final_done = 1'b1;
            end
        end
    end

    initial begin
        int rp;
        int rph;
        bit rld;

        repeat (3) step();
        rst_n = 1'b1;
        last_rise = cyc;
        step();

        // Nominal acquisition and lock at quarter phase.
        load_now(8'h40);
        repeat (10) do_edge(64, 1'b0, 0);

        // Half phase then three-quarter phase mid-stream.
        do_edge(32, 1'b1, 8'h80);
        repeat (6) do_edge(32, 1'b0, 0);
        do_edge(32, 1'b1, 8'hC0);
        repeat (5) do_edge(32, 1'b0, 0);

        // Reference loss, then fresh acquisition.
        idle(2500);
        repeat (6) do_edge(40, 1'b0, 0);

        // Too-fast reference, then recovery.
        repeat (4) do_edge(8, 1'b0, 0);
        repeat (4) do_edge(64, 1'b0, 0);

        // Jitter just outside and just inside tolerance.
        repeat (8) begin
            do_edge(64, 1'b0, 0);
            do_edge(66, 1'b0, 0);
        end
        repeat (8) begin
            do_edge(64, 1'b0, 0);
            do_edge(65, 1'b0, 0);
        end

        // Phase extremes.
        do_edge(64, 1'b1, 8'hFF);
        repeat (2) do_edge(64, 1'b0, 0);
        do_edge(64, 1'b1, 8'h00);
        repeat (2) do_edge(64, 1'b0, 0);

        // Randomized periods and phase loads.
        for (int i = 0; i < 60; i++) begin
            rp  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(500, 1500))
                                              : int'($urandom_range(16, 120));
            rld = ($urandom_range(0, 3) == 0);
            rph = int'($urandom_range(0, 255));
            do_edge(rp, rld, rph);
        end

        // Asynchronous reset while the product is being computed.
        repeat (4) do_edge(64, 1'b0, 0);
        pulse_reset();
        load_now(8'h20);
        repeat (5) do_edge(48, 1'b0, 0);

        repeat (5) step();
        done = 1'b1;
        for (int i = 0; i < 20 && !final_done; i++) step();
        step();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
